cordic_delta_seq: RTL and testbench
===================================

Name: cordic_delta_seq

Overview:
- Self-sequencing CORDIC direction generator. It is the parametrised successor of the free-running delta/residual-angle loop.
- Adds a start/done handshake, an internal iteration counter, an alpha table index output, rotation and vectoring modes, and a synchronous abort.
- Sits beside the x/y datapath. It drives one delta per iteration and the alpha ROM address, and returns the final residual angle.

Parameters:
- WIDTH, 16, two's-complement width of theta, alpha_i and the residual angle.
- ITER, 16, number of CORDIC iterations per operation (>= 2).
- IDX_W, 4, width of alpha_idx; must satisfy 2^IDX_W >= ITER.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin an operation; sampled only in IDLE.
- mode  input  1  0 = rotation, 1 = vectoring; latched on an accepted start.
- abort  input  1  synchronous cancel of the operation in progress.
- theta  input  WIDTH  initial angle, rotation mode; latched on start.
- alpha_i  input  WIDTH  atan(2^-i), from an external combinational ROM addressed by alpha_idx.
- y_sign  input  1  sign bit of the datapath y register; used in vectoring mode.
- alpha_idx  output  IDX_W  current iteration index i.
- delta  output  1  direction for iteration i; 1 = negative rotation (add alpha).
- delta_valid  output  1  high on every iteration cycle.
- busy  output  1  high while in ITER.
- done  output  1  one-cycle pulse when the operation completes.
- e_out  output  WIDTH  residual angle register (z).

Behaviour:
- Reset, asynchronous: state=IDLE; e_out=0; alpha_idx=0; busy=0; delta_valid=0; done=0; delta=0; latched mode=0.
- FSM states: IDLE, ITER, DONE.
- IDLE: on start=1:
  - e <= theta when mode=0, or 0 when mode=1.
  - idx <= 0; latch mode; go to ITER.
  - Without start, all registers hold.
- ITER: delta_valid=1 and busy=1.
  - delta is combinational: e[WIDTH-1] in rotation, ~y_sign in vectoring.
  - delta=1: e <= e + alpha_i. delta=0: e <= e - alpha_i.
  - idx increments each cycle. The cycle with idx=ITER-1 is the last update; the next state is DONE.
- DONE: done=1 for exactly one cycle; e_out holds the final residual; idx returns to 0; next state is IDLE.
- delta is forced to 0 whenever delta_valid=0.
- Arithmetic is modulo 2^WIDTH: wrap-around, no saturation, no overflow flag.
- Latency: start accepted at edge 0. Iteration k (k=0..ITER-1) occupies cycle k+1. done is high in cycle ITER+1. The next start can be accepted in cycle ITER+2.
- start while in ITER or DONE is ignored; it is not queued.
- abort:
  - In ITER it has priority over the update: next state is IDLE, e_out keeps its pre-abort value, done is never pulsed, idx returns to 0.
  - In IDLE or DONE it has no effect.
  - abort and start together in IDLE: start is accepted.
- mode and theta changes after acceptance have no effect until the next start. y_sign is sampled live every ITER cycle.
- rst_n asserted mid-operation: immediate return to reset values; no done pulse.

Test Plan:
- Rotation, WIDTH=16, ITER=4, alpha_i=0x1000 constant, theta=0x1800:
  - delta sequence 0,0,1,0.
  - e = 0x0800, 0xF800, 0x0800, 0xF800.
  - done high in cycle 5; e_out=0xF800; alpha_idx 0,1,2,3 during cycles 1-4.
- Vectoring, ITER=4, alpha_i=0x1000, y_sign held 0 -> delta=1 on all four cycles; final e_out=0x4000; theta ignored.
- Wrap: rotation, theta=0x8000, alpha_i=0x9000, ITER=2 -> first delta=1 and e=0x1000 (wrapped); second delta=0 and e=0x8000 (wrapped).
- Abort asserted in cycle 2 of a 4-iteration run -> IDLE next cycle; busy=0; done never pulses; e_out keeps its cycle-2 value; new start accepted immediately.
- start pulsed during ITER and during DONE -> ignored; exactly one done per accepted start; total cycles unchanged.
- rst_n low in cycle 3 -> all outputs zero asynchronously; after release, IDLE; a fresh start completes normally with done in cycle ITER+1.

Source files
------------

// File: rtl/cordic_delta_seq.sv
// ----------------------------------------------------------------------------
// cordic_delta_seq
//
// Self-sequencing CORDIC direction generator. It sits beside the x/y
// datapath. Each iteration it produces one rotation direction (delta) and
// the alpha ROM address (alpha_idx). It accumulates the residual angle z
// (e_out) from the ROM value alpha_i.
//
// Rotation mode (mode=0): z starts at theta, and delta follows the sign of z.
// Vectoring mode (mode=1): z starts at 0, and delta follows ~y_sign.
// All arithmetic on z wraps modulo 2^WIDTH.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        begin an operation (only honoured in IDLE)
//   mode         0 = rotation, 1 = vectoring (latched on start)
//   abort        cancel the operation in progress (ITER only)
//   theta        initial angle for rotation mode (latched on start)
//   alpha_i      atan(2^-i) from an external ROM addressed by alpha_idx
//   y_sign       sign of the datapath y register (live, vectoring mode)
//   alpha_idx    current iteration index
//   delta        direction for this iteration, 1 = add alpha
//   delta_valid  high on every iteration cycle
//   busy         high while iterating
//   done         one-cycle completion pulse
//   e_out        residual angle register
// ----------------------------------------------------------------------------
module cordic_delta_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] theta,
    input  logic [WIDTH-1:0] alpha_i,
    input  logic             y_sign,
    output logic [IDX_W-1:0] alpha_idx,
    output logic             delta,
    output logic             delta_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] e_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER - 1);

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] e_q, e_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    mode_q, mode_d;
    logic                    dir;

    // One micro-rotation of the angle accumulator; wrap-around is intended.
    function automatic logic signed [WIDTH-1:0] rotate_z(
        input logic signed [WIDTH-1:0] z,
        input logic signed [WIDTH-1:0] a,
        input logic                    add
    );
        return add ? (z + a) : (z - a);
    endfunction

    // Rotation drives z towards zero; vectoring drives y towards zero.
    assign dir = mode_q ? ~y_sign : e_q[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        e_d         = e_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        busy        = 1'b0;
        delta_valid = 1'b0;
        delta       = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort is ignored here, so start wins when both are high.
                if (start) begin
                    e_d     = mode ? '0 : $signed(theta);
                    mode_d  = mode;
                    idx_d   = '0;
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                busy        = 1'b1;
                delta_valid = 1'b1;
                delta       = dir;
                if (abort) begin
                    // Leave z untouched so the pre-abort residual stays visible.
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    e_d = rotate_z(e_q, $signed(alpha_i), dir);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            e_q     <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    assign alpha_idx = idx_q;
    assign e_out     = e_q;

endmodule

// File: tb/tb_cordic_delta_seq.sv
// ----------------------------------------------------------------------------
// tb_cordic_delta_seq
//
// Directed bench for cordic_delta_seq (WIDTH=16, ITER=4). A timeline model
// tracks the position inside an operation and the residual angle. A negedge
// compare process checks every output against that model on every cycle.
// Directed sequences add literal, hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_cordic_delta_seq;

    localparam int WIDTH = 16;
    localparam int ITER  = 4;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             mode;
    logic             abort;
    logic [WIDTH-1:0] theta;
    logic [WIDTH-1:0] alpha_i;
    logic             y_sign;
    logic [IDX_W-1:0] alpha_idx;
    logic             delta;
    logic             delta_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] e_out;

    int checks = 0;
    int errors = 0;

    cordic_delta_seq #(.WIDTH(WIDTH), .ITER(ITER), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .abort      (abort),
        .theta      (theta),
        .alpha_i    (alpha_i),
        .y_sign     (y_sign),
        .alpha_idx  (alpha_idx),
        .delta      (delta),
        .delta_valid(delta_valid),
        .busy       (busy),
        .done       (done),
        .e_out      (e_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    // pos = 0: idle. pos = 1..ITER: iteration pos-1. pos = ITER+1: done cycle.
    int               m_pos  = 0;
    logic [WIDTH-1:0] m_e    = '0;
    logic             m_mode = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos  = 0;
            m_e    = '0;
            m_mode = 1'b0;
        end else if (m_pos == 0) begin
            if (start) begin
                m_mode = mode;
                m_e    = mode ? 16'h0000 : theta;
                m_pos  = 1;
            end
        end else if (m_pos <= ITER) begin
            if (abort) begin
                m_pos = 0;
            end else begin
                if ((m_mode ? ~y_sign : m_e[WIDTH-1]) == 1'b1)
                    m_e = m_e + alpha_i;
                else
                    m_e = m_e - alpha_i;
                m_pos = m_pos + 1;
            end
        end else begin
            m_pos = 0;
        end
    end

    always @(negedge clk) begin
        logic iter_now;
        iter_now = (m_pos >= 1) && (m_pos <= ITER);
        chk("busy",        {31'd0, busy},        {31'd0, iter_now});
        chk("delta_valid", {31'd0, delta_valid}, {31'd0, iter_now});
        chk("done",        {31'd0, done},        {31'd0, (m_pos == ITER + 1)});
        chk("e_out",       {16'd0, e_out},       {16'd0, m_e});
        chk("alpha_idx",   {28'd0, alpha_idx},   iter_now ? 32'(m_pos - 1) : 32'd0);
        chk("delta",       {31'd0, delta},
            iter_now ? {31'd0, (m_mode ? ~y_sign : m_e[WIDTH-1])} : 32'd0);
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Returns 2 ns into cycle 1, the first iteration cycle.
    task automatic do_start(input logic m, input logic [WIDTH-1:0] th);
        @(posedge clk);
        #2;
        start = 1'b1;
        mode  = m;
        theta = th;
        next_cycle();
        start = 1'b0;
        mode  = ~m;
        theta = 16'h5A5A;
    endtask

    logic [WIDTH-1:0] rot_e [4];
    logic             rot_d [4];

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        mode    = 1'b0;
        abort   = 1'b0;
        theta   = '0;
        alpha_i = 16'h1000;
        y_sign  = 1'b0;
        rot_e   = '{16'h0800, 16'hF800, 16'h0800, 16'hF800};
        rot_d   = '{1'b0, 1'b0, 1'b1, 1'b0};

        #3;
        chk("rst_e_out", {16'd0, e_out}, 32'h0);
        chk("rst_busy",  {31'd0, busy},  32'h0);
        chk("rst_done",  {31'd0, done},  32'h0);
        chk("rst_delta", {31'd0, delta}, 32'h0);
        chk("rst_idx",   {28'd0, alpha_idx}, 32'h0);
        #20;
        rst_n = 1'b1;

        // Rotation: theta=0x1800, alpha=0x1000.
        do_start(1'b0, 16'h1800);
        for (int k = 1; k <= 4; k++) begin
            chk("rot_delta", {31'd0, delta}, {31'd0, rot_d[k-1]});
            chk("rot_idx", {28'd0, alpha_idx}, 32'(k - 1));
            chk("rot_done_low", {31'd0, done}, 32'h0);
            next_cycle();
            chk("rot_e", {16'd0, e_out}, {16'd0, rot_e[k-1]});
        end
        chk("rot_done", {31'd0, done}, 32'h1);
        chk("rot_final", {16'd0, e_out}, 32'h0000F800);
        next_cycle();
        chk("rot_done_pulse", {31'd0, done}, 32'h0);

        // Vectoring: y_sign held 0, theta ignored.
        y_sign = 1'b0;
        do_start(1'b1, 16'h7777);
        for (int k = 1; k <= 4; k++) begin
            chk("vec_delta", {31'd0, delta}, 32'h1);
            next_cycle();
        end
        chk("vec_done", {31'd0, done}, 32'h1);
        chk("vec_final", {16'd0, e_out}, 32'h00004000);

        // Vectoring with y_sign toggling live every cycle (model-checked).
        do_start(1'b1, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            y_sign = k[0];
            next_cycle();
        end
        y_sign = 1'b0;

        // Wrap-around: theta=0x8000, alpha=0x9000.
        alpha_i = 16'h9000;
        do_start(1'b0, 16'h8000);
        chk("wrap_d0", {31'd0, delta}, 32'h1);
        next_cycle();
        chk("wrap_e0", {16'd0, e_out}, 32'h00001000);
        chk("wrap_d1", {31'd0, delta}, 32'h0);
        next_cycle();
        chk("wrap_e1", {16'd0, e_out}, 32'h00008000);
        next_cycle();
        next_cycle();
        chk("wrap_done", {31'd0, done}, 32'h1);
        chk("wrap_final", {16'd0, e_out}, 32'h00008000);
        alpha_i = 16'h1000;

        // Abort in cycle 2, then an immediate restart.
        do_start(1'b0, 16'h1800);
        next_cycle();
        chk("abort_pre_e", {16'd0, e_out}, 32'h00000800);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_done", {31'd0, done}, 32'h0);
        chk("abort_e", {16'd0, e_out}, 32'h00000800);
        start = 1'b1;
        mode  = 1'b0;
        theta = 16'h1800;
        next_cycle();
        start = 1'b0;
        chk("restart_busy", {31'd0, busy}, 32'h1);
        for (int k = 2; k <= 5; k++) next_cycle();
        chk("restart_done", {31'd0, done}, 32'h1);
        chk("restart_final", {16'd0, e_out}, 32'h0000F800);

        // start pulsed during ITER (cycle 2) and DONE (cycle 5).
        do_start(1'b0, 16'h1800);
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        chk("ign_done", {31'd0, done}, 32'h1);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        chk("ign_idle_busy", {31'd0, busy}, 32'h0);
        chk("ign_idle_done", {31'd0, done}, 32'h0);
        next_cycle();
        chk("ign_still_idle", {31'd0, busy}, 32'h0);

        // Reset in cycle 3, then a fresh operation.
        do_start(1'b0, 16'h1800);
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'h0);
        chk("arst_dv",   {31'd0, delta_valid}, 32'h0);
        chk("arst_e",    {16'd0, e_out}, 32'h0);
        chk("arst_idx",  {28'd0, alpha_idx}, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        do_start(1'b0, 16'h1800);
        for (int k = 2; k <= 5; k++) begin
            chk("post_rst_done_low", {31'd0, done}, 32'h0);
            next_cycle();
        end
        chk("post_rst_done", {31'd0, done}, 32'h1);
        chk("post_rst_final", {16'd0, e_out}, 32'h0000F800);
        next_cycle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
